bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Shares the single memory bus between two masters: M0 is the CPU control unit and M1 is the loader/debug port.
//  Each master issues one-cycle start pulses. The arbiter latches each request and grants the bus round-robin.
//  It drives one bus transaction at a time and routes completion, or a timeout error, back to the owning master.
//  Sits between the control unit/datapath and the bus interface. Read data is wired straight from the bus, not through this block.
// PARAMETERS
//  AW       32  address width
//  DW       32  write data width
//  TIMEOUT  64  max WAIT cycles before abort; 0 disables the timeout; counter width is $clog2(TIMEOUT+1)
// PORTS
//  clk                    in   1   clock, rising edge
//  rst_n                  in   1   asynchronous active-low reset
//  m0_start, m1_start     in   1   one-cycle request pulse from the master
//  m0_mode, m1_mode       in   1   0 = read, 1 = write; sampled with start
//  m0_addr, m1_addr       in   AW  address; sampled with start
//  m0_wdata, m1_wdata     in   DW  write data; sampled with start
//  m0_rdata_valid, m1_rdata_valid  out 1  read-completion pulse to the master
//  m0_write_done, m1_write_done    out 1  write-completion pulse to the master
//  m0_err, m1_err         out  1   timeout-abort pulse to the master
//  BUS_start_transaction  out  1   one-cycle start pulse to the bus
//  BUS_mode               out  1   mode of the granted request
//  BUS_ADDR               out  AW  address of the granted request
//  BUS_WDATA              out  DW  write data of the granted request
//  BUS_rdata_valid        in   1   read complete, from the bus
//  BUS_write_done         in   1   write complete, from the bus
//  grant                  out  1   current or last owner (0 = M0, 1 = M1)
//  busy                   out  1   high in ISSUE and WAIT
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; both pending flags 0; state IDLE.
//   - last_grant = 1, so M0 wins the first tie.
//   - Reset mid-transaction abandons it. A later BUS completion seen in IDLE is ignored.
//  Capture:
//   - mX_start with pending[X] = 0 sets pending[X] and loads hold_mode/addr/wdata[X].
//   - mX_start with pending[X] = 1 is dropped silently; the held request is unchanged.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   - IDLE: if any pending, pick the winner and go to ISSUE.
//     Winner: if both are pending, take the master != last_grant; otherwise take the sole requester.
//     Register grant and load BUS_mode/ADDR/WDATA from that master's hold regs.
//   - ISSUE: BUS_start_transaction = 1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
//   - WAIT: BUS_mode/ADDR/WDATA held stable.
//     Completion: BUS_rdata_valid with mode 0, or BUS_write_done with mode 1.
//     On completion, mX_rdata_valid or mX_write_done (X = grant) is asserted combinationally in the same cycle.
//     Then clear pending[grant], set last_grant = grant, go to IDLE.
//     A completion of the wrong type, or any completion outside WAIT, is ignored.
//   - Timeout: if the counter reaches TIMEOUT-1 with no completion, pulse mX_err (registered, next cycle).
//     Then clear pending[grant], set last_grant = grant, go to IDLE.
//     Completion and timeout in the same cycle: completion wins, no err.
//  Latency:
//   - start at edge N -> BUS_start_transaction at N+2, when idle and uncontended.
//   - Back-to-back: next BUS_start_transaction is 2 cycles after the completion cycle.
//  Simultaneous events:
//   - Both starts in the same cycle: both are latched and served alternately.
//   - mX_start in the same cycle as its own completion: accepted. The pending clear takes precedence only for the old request; the new request is latched.
//  Completion pulses are gated by state == WAIT and grant, so they never reach the non-owner.
// TESTING
//  1. Reset, m0 read addr 0x100 -> BUS_start at +2 with ADDR 0x100, mode 0; BUS_rdata_valid -> m0_rdata_valid same cycle; m1 outputs stay 0.
//  2. m0 and m1 start in the same cycle (m0 write 0x10 data 0xAA, m1 read 0x20) -> M0 served first, then M1; grant sequence 0,1.
//  3. M1 is last owner, both request again -> M0 granted; four continuous dual requests alternate 0,1,0,1.
//  4. TIMEOUT=4, no bus response -> m0_err pulses once, pending cleared, returns to IDLE, a queued m1 request issues next.
//  5. m0_start repeated while pending with a new addr -> original addr issued; only one transaction occurs.
//  6. rst_n low during WAIT -> all outputs 0; a late BUS_write_done produces no master pulse; the next request issues normally.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the memory bus and the arbiter.
// The arbiter connects through the slave modport. The masters and the bus together form the master side.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_start;
  logic          m1_start;
  logic          m0_mode;
  logic          m1_mode;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic          m0_rdata_valid;
  logic          m1_rdata_valid;
  logic          m0_write_done;
  logic          m1_write_done;
  logic          m0_err;
  logic          m1_err;
  logic          BUS_start_transaction;
  logic          BUS_mode;
  logic [AW-1:0] BUS_ADDR;
  logic [DW-1:0] BUS_WDATA;
  logic          BUS_rdata_valid;
  logic          BUS_write_done;
  logic          grant;
  logic          busy;

  modport slave (
    input  m0_start, m1_start, m0_mode, m1_mode, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  BUS_rdata_valid, BUS_write_done,
    output m0_rdata_valid, m1_rdata_valid, m0_write_done, m1_write_done, m0_err, m1_err,
    output BUS_start_transaction, BUS_mode, BUS_ADDR, BUS_WDATA, grant, busy
  );

  modport master (
    output m0_start, m1_start, m0_mode, m1_mode, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output BUS_rdata_valid, BUS_write_done,
    input  m0_rdata_valid, m1_rdata_valid, m0_write_done, m1_write_done, m0_err, m1_err,
    input  BUS_start_transaction, BUS_mode, BUS_ADDR, BUS_WDATA, grant, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one memory bus between the CPU control unit (M0) and the loader/debug port (M1).
// Each master's request is latched. The bus runs one transaction at a time, and completion or a timeout error goes back to the owner.
module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter_if.slave   bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        r_state;
  logic [1:0]    r_pending;
  logic [1:0]    r_holdMode;
  logic [AW-1:0] r_holdAddr  [2];
  logic [DW-1:0] r_holdWdata [2];
  logic          r_lastGrant;
  logic          r_grant;
  logic          r_busy;
  logic          r_busStart;
  logic          r_busMode;
  logic [AW-1:0] r_busAddr;
  logic [DW-1:0] r_busWdata;
  logic [1:0]    r_err;
  logic [CW-1:0] r_count;

  logic [1:0]    w_start;
  logic [1:0]    w_mode;
  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];
  logic [1:0]    w_release;
  logic [1:0]    w_accept;
  logic          w_inWait;
  logic          w_rdDone;
  logic          w_wrDone;
  logic          w_complete;
  logic          w_timeout;
  logic          w_winner;

  assign w_start    = {bus.m1_start, bus.m0_start};
  assign w_mode     = {bus.m1_mode, bus.m0_mode};
  assign w_addr[0]  = bus.m0_addr;
  assign w_addr[1]  = bus.m1_addr;
  assign w_wdata[0] = bus.m0_wdata;
  assign w_wdata[1] = bus.m1_wdata;

  assign w_inWait   = (r_state == WAIT);
  assign w_rdDone   = w_inWait && !r_busMode && bus.BUS_rdata_valid;
  assign w_wrDone   = w_inWait &&  r_busMode && bus.BUS_write_done;
  assign w_complete = w_rdDone || w_wrDone;
  assign w_timeout  = w_inWait && !w_complete && (TIMEOUT != 0) && (r_count == CW'(TIMEOUT - 1));

  // A master may re-request in the very cycle its previous transaction retires.
  assign w_release  = {(w_complete || w_timeout) &&  r_grant,
                       (w_complete || w_timeout) && !r_grant};
  assign w_accept   = w_start & (~r_pending | w_release);
  assign w_winner   = (r_pending == 2'b11) ? ~r_lastGrant : r_pending[1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_accept[i]) begin
        r_holdMode[i]  <= w_mode[i];
        r_holdAddr[i]  <= w_addr[i];
        r_holdWdata[i] <= w_wdata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_release) | w_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_busy      <= 1'b0;
      r_busStart  <= 1'b0;
      r_busMode   <= 1'b0;
      r_busAddr   <= '0;
      r_busWdata  <= '0;
      r_err       <= '0;
      r_count     <= '0;
    end else begin
      r_busStart <= 1'b0;
      r_err      <= '0;
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_grant    <= w_winner;
            r_busMode  <= r_holdMode[w_winner];
            r_busAddr  <= r_holdAddr[w_winner];
            r_busWdata <= r_holdWdata[w_winner];
            r_busStart <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_count <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_complete || w_timeout) begin
            r_err       <= {w_timeout && r_grant, w_timeout && !r_grant};
            r_lastGrant <= r_grant;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completion pulses pass straight through, but only to the current owner.
  assign bus.m0_rdata_valid        = w_rdDone && !r_grant;
  assign bus.m1_rdata_valid        = w_rdDone &&  r_grant;
  assign bus.m0_write_done         = w_wrDone && !r_grant;
  assign bus.m1_write_done         = w_wrDone &&  r_grant;
  assign bus.m0_err                = r_err[0];
  assign bus.m1_err                = r_err[1];
  assign bus.BUS_start_transaction = r_busStart;
  assign bus.BUS_mode              = r_busMode;
  assign bus.BUS_ADDR              = r_busAddr;
  assign bus.BUS_WDATA             = r_busWdata;
  assign bus.grant                 = r_grant;
  assign bus.busy                  = r_busy;
endmodule
